loc_sram_vld: RTL and testbench

LOC_SRAM_VLD -- requirements
Module: loc_sram_vld

---
 rtl/loc_sram_pkg.sv | 30 +++
 rtl/loc_sram_vld_if.sv | 47 ++++
 rtl/loc_sram_mask_expand.sv | 26 ++
 rtl/loc_sram_vld.sv | 186 ++++++++++++++++++
 tb/tb_loc_sram_vld.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/loc_sram_pkg.sv
// ---------------------------------------------------------------------------
// loc_sram_pkg
// Shared constants, sweep-FSM state type and the element-to-bit-slice mapping
// for the loc_sram_vld row memory. Element e of a row lives in the slice
// [(D-1-e)*BW +: BW]. Its per-element mask/valid bit is bit D-1-e, so
// element 0 is always the most significant slice/bit.
// ---------------------------------------------------------------------------
package loc_sram_pkg;

  localparam int LOC_ADDR_SPACE = 4;    // row address width
  localparam int LOC_BW         = 5;    // bits per element
  localparam int LOC_D          = 256;  // elements per row

  // Post-reset valid-clear sweep versus normal operation
  typedef enum logic [1:0] {
    ST_SWEEP = 2'd0,
    ST_RUN   = 2'd1
  } sweep_state_e;

  // Bit position of element e inside a D-wide mask/valid vector
  function automatic int elem_bit(input int e, input int d);
    return d - 1 - e;
  endfunction

  // LSB of element e inside a D*BW-wide data row
  function automatic int elem_lsb(input int e, input int d, input int bw);
    return (d - 1 - e) * bw;
  endfunction

endpackage : loc_sram_pkg

// File: rtl/loc_sram_vld_if.sv
// ---------------------------------------------------------------------------
// loc_sram_vld_if
// Write/read bus of loc_sram_vld.
//   master : testbench / requester side (drives write and read requests)
//   slave  : memory side (drives rdata, rvalid, rvld, busy)
// Write : wsb (active low), wmode, bytemask, wdata, welem, wdata_elem, waddr
// Read  : rsb (active low), rclr, raddr -> rdata, rvalid, rvld
// Status: busy (post-reset valid sweep in progress)
// ---------------------------------------------------------------------------
interface loc_sram_vld_if
  import loc_sram_pkg::*;
#(
  parameter int ADDR_SPACE = LOC_ADDR_SPACE,
  parameter int BW         = LOC_BW,
  parameter int D          = LOC_D
) ();

  localparam int WELEM_W = (D > 1) ? $clog2(D) : 1;

  logic                  wsb;
  logic                  wmode;
  logic [D-1:0]          bytemask;
  logic [D*BW-1:0]       wdata;
  logic [WELEM_W-1:0]    welem;
  logic [BW-1:0]         wdata_elem;
  logic [ADDR_SPACE-1:0] waddr;
  logic                  rsb;
  logic                  rclr;
  logic [ADDR_SPACE-1:0] raddr;
  logic [D*BW-1:0]       rdata;
  logic [D-1:0]          rvalid;
  logic                  rvld;
  logic                  busy;

  modport master (
    output wsb, wmode, bytemask, wdata, welem, wdata_elem, waddr,
    output rsb, rclr, raddr,
    input  rdata, rvalid, rvld, busy
  );

  modport slave (
    input  wsb, wmode, bytemask, wdata, welem, wdata_elem, waddr,
    input  rsb, rclr, raddr,
    output rdata, rvalid, rvld, busy
  );

endinterface : loc_sram_vld_if

// File: rtl/loc_sram_mask_expand.sv
// ---------------------------------------------------------------------------
// loc_sram_mask_expand
// Expands a D-bit per-element select vector into a D*BW-bit data mask by
// replicating each select bit over its element slice.
//   sel_i  [D-1:0]     : per-element select, bit D-1 = element 0
//   mask_o [D*BW-1:0]  : bit mask aligned with the row data layout
// ---------------------------------------------------------------------------
module loc_sram_mask_expand
  import loc_sram_pkg::*;
#(
  parameter int D  = LOC_D,
  parameter int BW = LOC_BW
) (
  input  logic [D-1:0]    sel_i,
  output logic [D*BW-1:0] mask_o
);

  // Replicate each element select across that element's data slice
  always_comb begin
    mask_o = '0;
    for (int e = 0; e < D; e++) begin
      mask_o[elem_lsb(e, D, BW) +: BW] = {BW{sel_i[elem_bit(e, D)]}};
    end
  end

endmodule : loc_sram_mask_expand

// File: rtl/loc_sram_vld.sv
// ---------------------------------------------------------------------------
// loc_sram_vld
// Row-organised SRAM model (DEPTH rows of D elements x BW bits) with one
// valid bit per element.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset; restarts the valid-clear sweep
//   bus  : loc_sram_vld_if.slave
//          write  - wsb=0: wmode=0 masked row write (bytemask 1 = keep),
//                          wmode=1 single element welem <- wdata_elem
//          read   - rsb=0: rdata/rvalid <= row raddr next cycle, rvld=1;
//                          rclr=1 also clears that row's valid bits
//          busy   - high while rows 0..DEPTH-1 have their valid bits cleared
// Reads return pre-write contents on a same-row collision. With a
// same-row write and read-clear, newly written elements end up valid.
// The data array itself is never reset.
// ---------------------------------------------------------------------------
module loc_sram_vld
  import loc_sram_pkg::*;
#(
  parameter int ADDR_SPACE = LOC_ADDR_SPACE,
  parameter int BW         = LOC_BW,
  parameter int D          = LOC_D
) (
  input  logic           clk,
  input  logic           rst,
  loc_sram_vld_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_SPACE;
  localparam int DW    = D * BW;

  // Storage
  logic [DW-1:0]         mem_q [DEPTH];
  logic [D-1:0]          vld_q [DEPTH];

  // Sweep FSM
  sweep_state_e          state_q, state_d;
  logic [ADDR_SPACE-1:0] sweep_q, sweep_d;
  logic                  busy_q, busy_d;

  // Read output registers
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [D-1:0]          rvalid_q, rvalid_d;
  logic                  rvld_q, rvld_d;

  // Request decode
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  rd_clr_s;
  logic                  clr_same_s;
  logic [D-1:0]          wsel_s;
  logic [DW-1:0]         wrow_s;
  logic [DW-1:0]         wmask_s;
  logic [DW-1:0]         mem_wr_s;
  logic [D-1:0]          vld_wr_s;

  // Qualify requests: nothing is accepted during reset or the sweep
  always_comb begin
    wr_en_s    = ~bus.wsb & ~busy_q & ~rst;
    rd_en_s    = ~bus.rsb & ~busy_q & ~rst;
    rd_clr_s   = rd_en_s & bus.rclr;
    clr_same_s = rd_clr_s & (bus.raddr == bus.waddr);
  end

  // Per-element write select and aligned write data for both write modes
  always_comb begin
    wsel_s = '0;
    wrow_s = '0;
    if (bus.wmode) begin
      // A welem outside 0..D-1 matches no element and so writes nothing
      for (int e = 0; e < D; e++) begin
        wsel_s[elem_bit(e, D)]         = (int'(bus.welem) == e);
        wrow_s[elem_lsb(e, D, BW) +: BW] = bus.wdata_elem;
      end
    end else begin
      wsel_s = ~bus.bytemask;
      wrow_s = bus.wdata;
    end
  end

  loc_sram_mask_expand #(
    .D  (D),
    .BW (BW)
  ) u_mask_expand (
    .sel_i  (wsel_s),
    .mask_o (wmask_s)
  );

  // Merged row data and valid vector for the addressed write row
  always_comb begin
    mem_wr_s = (mem_q[bus.waddr] & ~wmask_s) | (wrow_s & wmask_s);
    // A same-cycle read-clear of this row drops old valids; set bits win
    vld_wr_s = (vld_q[bus.waddr] & ~{D{clr_same_s}}) | wsel_s;
  end

  // Data array write port (no reset)
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[bus.waddr] <= mem_wr_s;
    end
  end

  // Valid array: sweep clear, read-clear, then write-set (write row last)
  always_ff @(posedge clk) begin
    if (busy_q && !rst) begin
      vld_q[sweep_q] <= '0;
    end else begin
      if (rd_clr_s) begin
        vld_q[bus.raddr] <= '0;
      end
      if (wr_en_s) begin
        vld_q[bus.waddr] <= vld_wr_s;
      end
    end
  end

  // Sweep FSM next-state: walk rows 0..DEPTH-1 then run
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_SWEEP: begin
        if (sweep_q == {ADDR_SPACE{1'b1}}) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + {{(ADDR_SPACE-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_SWEEP;
        sweep_d = '0;
      end
    endcase
    busy_d = (state_d == ST_SWEEP);
  end

  // Sweep FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SWEEP;
      sweep_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      busy_q  <= busy_d;
    end
  end

  // Read output next-state: capture on accepted read, otherwise hold
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rvld_d   = rd_en_s;
    if (rd_en_s) begin
      rdata_d  = mem_q[bus.raddr];
      rvalid_d = vld_q[bus.raddr];
    end else begin
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
    end
  end

  // Read output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
      rvld_q   <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rvld_q   <= rvld_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rvld   = rvld_q;
  assign bus.busy   = busy_q;

endmodule : loc_sram_vld

// File: tb/tb_loc_sram_vld.sv
module tb_loc_sram_vld;

  localparam int AS    = 4;
  localparam int BW    = 5;
  localparam int D     = 256;
  localparam int DEPTH = 16;
  localparam int DW    = D * BW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  loc_sram_vld_if #(.ADDR_SPACE(AS), .BW(BW), .D(D)) bus ();

  loc_sram_vld #(.ADDR_SPACE(AS), .BW(BW), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural reference model: element-level arrays
  logic [BW-1:0] m_data  [DEPTH][D];
  bit            m_known [DEPTH][D];
  bit            m_vld   [DEPTH][D];
  logic [DW-1:0] e_rdata;
  logic [DW-1:0] e_known;
  logic [D-1:0]  e_rvalid;
  logic          e_rvld;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [BW-1:0] elem(input logic [DW-1:0] v, input int e);
    return v[(D-1-e)*BW +: BW];
  endfunction

  function automatic logic [D-1:0] row_vld(input int r);
    logic [D-1:0] v;
    for (int e = 0; e < D; e++) v[D-1-e] = m_vld[r][e];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_rdata(input string tag);
    int bad;
    n_checks++;
    assert ((bus.rdata & e_known) === (e_rdata & e_known)) n_pass++;
    else begin
      bad = -1;
      for (int e = D-1; e >= 0; e--)
        if ((elem(bus.rdata, e) & elem(e_known, e)) !== (elem(e_rdata, e) & elem(e_known, e))) bad = e;
      $error("FAIL %s: element %0d observed %h expected %h", tag, bad,
             elem(bus.rdata, bad), elem(e_rdata, bad));
    end
  endtask

  task automatic idle();
    bus.wsb = 1'b1; bus.wmode = 1'b0; bus.bytemask = '1; bus.wdata = '0;
    bus.welem = '0; bus.wdata_elem = '0; bus.waddr = '0;
    bus.rsb = 1'b1; bus.rclr = 1'b0; bus.raddr = '0;
  endtask

  task automatic rand_wdata();
    for (int i = 0; i < DW/32; i++) bus.wdata[i*32 +: 32] = $urandom;
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++)
      for (int e = 0; e < D; e++) m_vld[r][e] = 1'b0;
    e_rdata = '0; e_known = '1; e_rvalid = '0; e_rvld = 1'b0;
  endtask

  // One operating cycle: predict, update model, clock, compare
  task automatic cycle();
    int ra, wa;
    bit wr;
    logic [BW-1:0] val;
    ra = int'(bus.raddr);
    wa = int'(bus.waddr);
    if (!bus.rsb) begin
      e_rvld = 1'b1;
      for (int e = 0; e < D; e++) begin
        e_rdata[(D-1-e)*BW +: BW] = m_data[ra][e];
        e_known[(D-1-e)*BW +: BW] = {BW{m_known[ra][e]}};
      end
      e_rvalid = row_vld(ra);
      if (bus.rclr) for (int e = 0; e < D; e++) m_vld[ra][e] = 1'b0;
    end else begin
      e_rvld = 1'b0;
    end
    if (!bus.wsb) begin
      for (int e = 0; e < D; e++) begin
        wr  = bus.wmode ? (int'(bus.welem) == e) : !bus.bytemask[D-1-e];
        val = bus.wmode ? bus.wdata_elem : bus.wdata[(D-1-e)*BW +: BW];
        if (wr) begin
          m_data[wa][e] = val; m_known[wa][e] = 1'b1; m_vld[wa][e] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    chk("rvld", 256'(bus.rvld), 256'(e_rvld));
    chk("rvalid", bus.rvalid, e_rvalid);
    chk_rdata("rdata");
  endtask

  task automatic load_param(input int index, input logic [DW-1:0] row);
    bus.wsb = 1'b0; bus.wmode = 1'b0; bus.bytemask = '0;
    bus.waddr = AS'(index); bus.wdata = row;
    cycle();
    idle();
  endtask

  task automatic do_read(input int r, input bit clr);
    bus.rsb = 1'b0; bus.raddr = AS'(r); bus.rclr = clr;
    cycle();
    idle();
  endtask

  int n;
  logic [D-1:0]  exp_v;
  logic [DW-1:0] row;

  initial begin
    for (int r = 0; r < DEPTH; r++)
      for (int e = 0; e < D; e++) begin m_known[r][e] = 1'b0; m_data[r][e] = '0; end
    idle();
    model_reset();

    // Reset state and sweep length
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", 256'(bus.busy), 256'(1));
    chk("rst_rvld", 256'(bus.rvld), 256'(0));
    chk("rst_rvalid", bus.rvalid, 256'(0));
    chk_rdata("rst_rdata");
    rst = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.busy) n++; else break;
    end
    chk("busy_len", 256'(n), 256'(16));
    do_read(5, 1'b0);
    chk("r5_rvalid_zero", bus.rvalid, 256'(0));
    cycle();  // idle cycle: rvld low, outputs hold

    // Masked write to row 3, element 0 only
    rand_wdata();
    bus.wsb = 1'b0; bus.wmode = 1'b0; bus.waddr = 4'd3;
    bus.bytemask = '1; bus.bytemask[D-1] = 1'b0;
    bus.wdata[(D-1)*BW +: BW] = 5'h1F;
    cycle(); idle();
    do_read(3, 1'b0);
    exp_v = '0; exp_v[255] = 1'b1;
    chk("mw_elem0", 256'(elem(bus.rdata, 0)), 256'(5'h1F));
    chk("mw_rvalid", bus.rvalid, exp_v);

    // Single-element write to row 7 over a preloaded, valid-cleared row
    for (int i = 0; i < DW/32; i++) row[i*32 +: 32] = $urandom;
    load_param(7, row);
    do_read(7, 1'b0);
    chk("lp_rvalid", bus.rvalid, {D{1'b1}});
    do_read(7, 1'b1);
    bus.wsb = 1'b0; bus.wmode = 1'b1; bus.waddr = 4'd7;
    bus.welem = 8'd10; bus.wdata_elem = 5'h0A;
    cycle(); idle();
    do_read(7, 1'b0);
    exp_v = '0; exp_v[245] = 1'b1;
    chk("sw_elem10", 256'(elem(bus.rdata, 10)), 256'(5'h0A));
    chk("sw_elem11", 256'(elem(bus.rdata, 11)), 256'(row[(D-1-11)*BW +: BW]));
    chk("sw_rvalid", bus.rvalid, exp_v);

    // Read-clear then re-read
    do_read(7, 1'b1);
    chk("rc_elem10", 256'(elem(bus.rdata, 10)), 256'(5'h0A));
    chk("rc_bit245", 256'(bus.rvalid[245]), 256'(1));
    do_read(7, 1'b0);
    chk("rc2_rvalid", bus.rvalid, 256'(0));
    chk("rc2_elem10", 256'(elem(bus.rdata, 10)), 256'(5'h0A));

    // Same-cycle write + read-clear on row 2
    bus.wsb = 1'b0; bus.wmode = 1'b1; bus.waddr = 4'd2; bus.welem = 8'd0; bus.wdata_elem = 5'h03;
    cycle(); idle();
    bus.wsb = 1'b0; bus.wmode = 1'b1; bus.waddr = 4'd2; bus.welem = 8'd0; bus.wdata_elem = 5'h11;
    bus.rsb = 1'b0; bus.rclr = 1'b1; bus.raddr = 4'd2;
    cycle(); idle();
    chk("col_elem0_old", 256'(elem(bus.rdata, 0)), 256'(5'h03));
    chk("col_bit255", 256'(bus.rvalid[255]), 256'(1));
    do_read(2, 1'b0);
    exp_v = '0; exp_v[255] = 1'b1;
    chk("col_elem0_new", 256'(elem(bus.rdata, 0)), 256'(5'h11));
    chk("col_rvalid", bus.rvalid, exp_v);

    // Randomised traffic against the model
    for (int i = 0; i < 200; i++) begin
      bus.wsb   = 1'($urandom_range(0, 1));
      bus.wmode = 1'($urandom_range(0, 1));
      for (int k = 0; k < D/32; k++) bus.bytemask[k*32 +: 32] = $urandom;
      rand_wdata();
      bus.welem      = 8'($urandom_range(0, D-1));
      bus.wdata_elem = 5'($urandom);
      bus.waddr      = 4'($urandom_range(0, 3));
      bus.rsb        = 1'($urandom_range(0, 1));
      bus.rclr       = ($urandom_range(0, 3) == 0);
      bus.raddr      = 4'($urandom_range(0, 3));
      cycle();
    end
    idle();

    // Reset with a pending read, then reset again mid-sweep
    bus.rsb = 1'b0; bus.raddr = 4'd1;
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("rst2_rvld", 256'(bus.rvld), 256'(0));
    chk("rst2_rvalid", bus.rvalid, 256'(0));
    chk_rdata("rst2_rdata");
    rst = 1'b0; idle();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("sweep_busy", 256'(bus.busy), 256'(1));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rand_wdata();
    bus.wsb = 1'b0; bus.wmode = 1'b0; bus.bytemask = '0; bus.waddr = 4'd4;
    bus.rsb = 1'b0; bus.rclr = 1'b0; bus.raddr = 4'd4;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("busy_rvld", 256'(bus.rvld), 256'(0));
      if (bus.busy) n++; else break;
    end
    chk("busy_len2", 256'(n), 256'(16));
    idle();
    do_read(4, 1'b0);
    chk("busy_wr_ignored", bus.rvalid, 256'(0));
    do_read(3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_loc_sram_vld
